// File: rtl/swim_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : swim_frame_tx
// Brief    : SWIM low-speed frame transmitter with ACK/NACK decode for an
//            open-drain STM8 debug line.
// Revision : 1.0 - initial release
// ============================================================================
module swim_frame_tx #(
    parameter int BIT_CYCLES   = 22,
    parameter int SHORT_CYCLES = 2,
    parameter int SAMPLE_POINT = 11,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_cmd,
    input  logic [7:0] data,
    input  logic       swim_in,
    output logic       swim_oe,
    output logic       busy,
    output logic       done,
    output logic       ack,
    output logic       nack,
    output logic       timeout
);

    localparam int c_CNT_MAX0 = (BIT_CYCLES > ACK_TIMEOUT) ? BIT_CYCLES : ACK_TIMEOUT;
    localparam int c_CNT_MAX  = (c_CNT_MAX0 > SAMPLE_POINT) ? c_CNT_MAX0 : SAMPLE_POINT;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(BIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE    = c_CNT_W'(SAMPLE_POINT);
    localparam logic [c_CNT_W-1:0] c_LOW_ONE   = c_CNT_W'(SHORT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LOW_ZERO  = c_CNT_W'(BIT_CYCLES - SHORT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEND       = 3'd1,
        S_ACK_WAIT   = 3'd2,
        S_ACK_SAMPLE = 3'd3,
        S_ACK_END    = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [3:0]           r_bit_q, w_bit_d;
    logic [9:0]           r_frame_q, w_frame_d;
    logic                 r_is_cmd_q, w_is_cmd_d;
    logic                 r_ack_q, w_ack_d;
    logic                 r_nack_q, w_nack_d;
    logic                 r_timeout_q, w_timeout_d;
    logic                 r_swim_oe_q, w_swim_oe_d;
    logic                 r_busy_q, w_busy_d;
    logic                 r_done_q, w_done_d;
    logic [1:0]           r_sync_q, w_sync_d;
    logic                 r_sw_prev_q, w_sw_prev_d;

    logic                 w_sw_s;
    logic                 w_fall;
    logic [3:0]           w_bit_last;
    logic [c_CNT_W-1:0]   w_low_len;

    assign w_sw_s     = r_sync_q[1];
    assign w_fall     = r_sw_prev_q & ~w_sw_s;
    assign w_bit_last = r_is_cmd_q ? 4'd4 : 4'd9;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_bit_d     = r_bit_q;
        w_frame_d   = r_frame_q;
        w_is_cmd_d  = r_is_cmd_q;
        w_ack_d     = r_ack_q;
        w_nack_d    = r_nack_q;
        w_timeout_d = r_timeout_q;
        w_sync_d    = {r_sync_q[0], swim_in};
        w_sw_prev_d = w_sw_s;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    // Frame is left-aligned: header, payload MSB first, parity.
                    if (is_cmd) begin
                        w_frame_d = {1'b0, data[2:0], ^data[2:0], 5'b0_0000};
                    end else begin
                        w_frame_d = {1'b0, data, ^data};
                    end
                    w_is_cmd_d  = is_cmd;
                    w_ack_d     = 1'b0;
                    w_nack_d    = 1'b0;
                    w_timeout_d = 1'b0;
                    w_cnt_d     = '0;
                    w_bit_d     = 4'd0;
                    w_state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (r_cnt_q == c_BIT_LAST) begin
                    w_cnt_d = '0;
                    if (r_bit_q == w_bit_last) begin
                        w_state_d = S_ACK_WAIT;
                    end else begin
                        w_bit_d   = r_bit_q + 4'd1;
                        w_frame_d = {r_frame_q[8:0], 1'b0};
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_ACK_WAIT: begin
                if (w_fall) begin
                    w_cnt_d   = '0;
                    w_state_d = S_ACK_SAMPLE;
                end else if (r_cnt_q == c_TO_LAST) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_ACK_SAMPLE: begin
                if (r_cnt_q == c_SAMPLE) begin
                    // A short target pulse has already ended here: high means ACK.
                    w_ack_d   = w_sw_s;
                    w_nack_d  = ~w_sw_s;
                    w_cnt_d   = '0;
                    w_state_d = S_ACK_END;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_ACK_END: begin
                if (w_sw_s) begin
                    w_state_d = S_DONE;
                end else if (r_cnt_q == c_TO_LAST) begin
                    w_timeout_d = 1'b1;
                    w_state_d   = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from next-state values so the pin never glitches.
        w_low_len   = w_frame_d[9] ? c_LOW_ONE : c_LOW_ZERO;
        w_swim_oe_d = (w_state_d == S_SEND) && (w_cnt_d < w_low_len);
        w_busy_d    = (w_state_d != S_IDLE);
        w_done_d    = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_bit_q     <= 4'd0;
            r_frame_q   <= 10'd0;
            r_is_cmd_q  <= 1'b0;
            r_ack_q     <= 1'b0;
            r_nack_q    <= 1'b0;
            r_timeout_q <= 1'b0;
            r_swim_oe_q <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_sync_q    <= 2'b11;
            r_sw_prev_q <= 1'b1;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_bit_q     <= w_bit_d;
            r_frame_q   <= w_frame_d;
            r_is_cmd_q  <= w_is_cmd_d;
            r_ack_q     <= w_ack_d;
            r_nack_q    <= w_nack_d;
            r_timeout_q <= w_timeout_d;
            r_swim_oe_q <= w_swim_oe_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_sync_q    <= w_sync_d;
            r_sw_prev_q <= w_sw_prev_d;
        end
    end

    assign swim_oe = r_swim_oe_q;
    assign busy    = r_busy_q;
    assign done    = r_done_q;
    assign ack     = r_ack_q;
    assign nack    = r_nack_q;
    assign timeout = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_swim_frame_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_swim_frame_tx
// Brief    : Self-checking bench for swim_frame_tx with a simple target model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swim_frame_tx;

    localparam int c_BIT   = 22;
    localparam int c_SHORT = 2;
    localparam int c_LONG  = c_BIT - c_SHORT;
    localparam int c_TO    = 64;

    typedef struct {
        logic       is_cmd;
        logic [7:0] data;
        int         resp_len;   // target low time in cycles, 0 = silent
        logic       mid_start;
        logic       exp_ack;
        logic       exp_nack;
        logic       exp_to;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       is_cmd;
    logic [7:0] data;
    logic       swim_in;
    logic       swim_oe;
    logic       busy;
    logic       done;
    logic       ack;
    logic       nack;
    logic       timeout;
    logic       tgt_low;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int run_len = 0;
    vec_t vecs[7];

    // Open-drain line: either side may pull low.
    assign swim_in = ~(swim_oe | tgt_low);

    always #5 clk = ~clk;

    swim_frame_tx dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .is_cmd  (is_cmd),
        .data    (data),
        .swim_in (swim_in),
        .swim_oe (swim_oe),
        .busy    (busy),
        .done    (done),
        .ack     (ack),
        .nack    (nack),
        .timeout (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void push_exp(input logic cmd, input logic [7:0] d);
        logic [7:0] pl;
        logic       par;
        int         n;
        n   = cmd ? 3 : 8;
        pl  = cmd ? {d[2:0], 5'b0_0000} : d;
        par = cmd ? ^d[2:0] : ^d;
        exp_q.push_back(c_LONG);
        for (int i = 0; i < n; i++) exp_q.push_back(pl[7-i] ? c_SHORT : c_LONG);
        exp_q.push_back(par ? c_SHORT : c_LONG);
    endfunction

    // Scoreboard: each low run on swim_oe pops one expected slot length.
    always @(negedge clk) begin
        if (reset) begin
            run_len = 0;
        end else if (swim_oe) begin
            run_len++;
        end else if (run_len != 0) begin
            if (exp_q.size() == 0) chk("oe_extra_run", run_len, 0);
            else                   chk("oe_low_run", run_len, exp_q.pop_front());
            run_len = 0;
        end
    end

    task automatic run_frame(input vec_t v);
        int s_len;
        int d;
        int done_cnt;
        s_len    = (v.is_cmd ? 5 : 10) * c_BIT;
        d        = -1;
        done_cnt = 0;
        @(negedge clk);
        start  = 1'b1;
        is_cmd = v.is_cmd;
        data   = v.data;
        push_exp(v.is_cmd, v.data);
        @(posedge clk);
        for (int i = 0; i < s_len + 200; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (v.mid_start && i == 30) begin
                start  = 1'b1;
                is_cmd = 1'b0;
                data   = 8'h00;
            end
            if (v.mid_start && i == 31) start = 1'b0;
            tgt_low = (v.resp_len > 0) && (i >= s_len + 3) && (i < s_len + 3 + v.resp_len);
            if (done) begin
                if (d < 0) d = i;
                done_cnt++;
            end
            if (d >= 0 && i == d)     chk("busy_at_done", busy, 1);
            if (d >= 0 && i == d + 1) chk("busy_after_done", busy, 0);
            if (d >= 0 && i == d + 2) break;
        end
        if (d < 0) begin
            chk("done_seen", 0, 1);
        end else begin
            chk("done_pulses", done_cnt, 1);
            chk("done_after_send", (d >= s_len), 1);
            if (v.resp_len == 0) chk("timeout_done_cycle", d, s_len + c_TO);
            chk("ack", ack, v.exp_ack);
            chk("nack", nack, v.exp_nack);
            chk("timeout", timeout, v.exp_to);
        end
        tgt_low = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 2,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hF5, 2,   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h01, 20,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h3C, 0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h96, 2,   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h07, 100, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h02, 2,   1'b0, 1'b1, 1'b0, 1'b0};

        reset   = 1'b1;
        start   = 1'b0;
        is_cmd  = 1'b0;
        data    = 8'h00;
        tgt_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_swim_oe", swim_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", ack, 0);
        chk("rst_nack", nack, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Asynchronous reset in the middle of slot 4 (a '0' bit of 0xA5).
        @(negedge clk);
        start  = 1'b1;
        is_cmd = 1'b0;
        data   = 8'hA5;
        push_exp(1'b0, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4 * c_BIT + 5) @(negedge clk);
        chk("oe_before_reset", swim_oe, 1);
        chk("busy_before_reset", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_swim_oe", swim_oe, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ack", ack, 0);
        chk("arst_nack", nack, 0);
        chk("arst_timeout", timeout, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_frame('{1'b0, 8'hC3, 2, 1'b0, 1'b1, 1'b0, 1'b0});

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
